mvm_stream_param: RTL

- Parametrised streaming matrix-vector unit: computes y = W*x + b for an M x N signed matrix W, N-vector x and M-vector bias b.
- Operands arrive as a single byte-serial valid/ready stream. Results leave as a valid/ready stream.
- Successor to the fixed 3x3 unit. Adds arbitrary M/N, parametrised widths, matrix-reuse mode (skip reloading W) and a pipelined MAC.
- Sits between the input stream source and the result sink in the accelerator datapath.

---
 rtl/mvm_stream_param_pkg.sv | 27 ++
 rtl/mvm_stream_param_if.sv | 30 +++
 rtl/mvm_stream_param_mac.sv | 108 ++++++++++
 rtl/mvm_stream_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mvm_stream_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvm_pkg
// Description : Shared types and sizing helpers for the streaming
//               matrix-vector unit (FSM states, counter widths, frame length).
// Revision    : 1.0 - initial release
// ============================================================================
package mvm_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } mvm_state_e;

  // Width of a counter that indexes n items; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of input beats in a frame: full load or bias+vector only.
  function automatic int frame_len(input int m, input int n, input bit reuse);
    return reuse ? (m + n) : (m * n + m + n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_stream_param_if.sv
`default_nettype none
// ============================================================================
// Module      : mvm_stream_param_if
// Description : Operand input stream and result output stream of the
//               matrix-vector unit. slave = unit side, master = source/sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface mvm_stream_param_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [IN_W-1:0]  data_in;
  logic                    reuse_w;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] data_out;

  modport slave (
    input  s_valid, data_in, reuse_w, m_ready,
    output s_ready, m_valid, data_out
  );

  modport master (
    output s_valid, data_in, reuse_w, m_ready,
    input  s_ready, m_valid, data_out
  );
endinterface
`default_nettype wire

// File: rtl/mvm_stream_param_mac.sv
`default_nettype none
// ============================================================================
// Module      : mvm_mac
// Description : Two-stage multiply-accumulate. Stage 1 registers the product,
//               stage 2 adds it to either the seed (first term of a row) or
//               the running sum. valid_o pulses with the finished row sum.
//               Optional macro MVM_SAT_EN: sticky per-row saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_mac #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_i,
  input  logic                    clear_i,
  input  logic                    last_i,
  input  logic signed [OUT_W-1:0] seed_i,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] result_o,
  output logic                    valid_o
);
  localparam int PROD_W = 2 * IN_W;

  logic                    s1_valid_q, s1_clear_q, s1_last_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic signed [OUT_W-1:0] s1_seed_q;
  logic signed [OUT_W-1:0] acc_q, acc_d;
  logic                    valid_q;
  logic signed [OUT_W-1:0] w_prod_ext;
  logic signed [OUT_W-1:0] w_base;

  assign w_prod_ext = OUT_W'(s1_prod_q);
  assign w_base     = s1_clear_q ? s1_seed_q : acc_q;

  // Stage 1: register the full-precision product alongside its row tags
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_clear_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_prod_q  <= '0;
      s1_seed_q  <= '0;
    end else begin
      s1_valid_q <= valid_i;
      s1_clear_q <= clear_i;
      s1_last_q  <= last_i;
      s1_prod_q  <= PROD_W'(a_i) * PROD_W'(b_i);
      s1_seed_q  <= seed_i;
    end
  end

`ifdef MVM_SAT_EN
  logic             sat_q, sat_d;
  logic [OUT_W:0]   w_sum;
  logic             w_sticky;

  assign w_sticky = !s1_clear_q && sat_q;
  assign w_sum    = {w_base[OUT_W-1], w_base} + {w_prod_ext[OUT_W-1], w_prod_ext};

  // Stage 2: accumulate with clamp; once a row clamps it stays clamped
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (s1_valid_q) begin
      if (w_sticky) begin
        acc_d = acc_q;
        sat_d = 1'b1;
      end else if (w_sum[OUT_W] != w_sum[OUT_W-1]) begin
        sat_d = 1'b1;
        acc_d = w_sum[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        sat_d = 1'b0;
        acc_d = w_sum[OUT_W-1:0];
      end
    end
  end

  // Sticky saturation flag for the row in progress
  always_ff @(posedge clk) begin
    if (!reset) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`else
  // Stage 2: two's-complement accumulate, wraps on overflow
  always_comb begin
    acc_d = acc_q;
    if (s1_valid_q) acc_d = w_base + w_prod_ext;
  end
`endif

  // Stage 2 register: running sum and row-complete strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= s1_valid_q && s1_last_q;
    end
  end

  assign result_o = acc_q;
  assign valid_o  = valid_q;
endmodule
`default_nettype wire

// File: rtl/mvm_stream_param.sv
`default_nettype none
// ============================================================================
// Module      : mvm_stream_param
// Description : Streaming y = W*x + b. Operands arrive byte-serially
//               (W row-major, b, x; or b, x when reusing W), results leave
//               as a valid/ready stream. Optional macro MVM_SAT_EN selects
//               saturating accumulation inside mvm_mac.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_stream_param
  import mvm_pkg::*;
#(
  parameter int M     = 3,
  parameter int N     = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input logic              clk,
  input logic              reset,
  mvm_stream_param_if.slave bus
);
  localparam int MN    = M * N;
  localparam int TOTAL = frame_len(M, N, 1'b0);
  localparam int PW    = cnt_w(TOTAL);
  localparam int WAW   = cnt_w(MN);
  localparam int RAW   = cnt_w(M);
  localparam int CAW   = cnt_w(N);

  mvm_state_e state_q, state_d;
  logic                    s_ready_q, s_ready_d;
  logic                    m_valid_q, m_valid_d;
  logic signed [OUT_W-1:0] data_out_q, data_out_d;
  logic [PW-1:0]           in_ptr_q, in_ptr_d;
  logic                    w_loaded_q, w_loaded_d;
  logic [WAW-1:0]          iss_idx_q, iss_idx_d;
  logic [RAW-1:0]          iss_row_q, iss_row_d;
  logic [CAW-1:0]          iss_col_q, iss_col_d;
  logic                    iss_done_q, iss_done_d;
  logic [RAW-1:0]          ret_row_q, ret_row_d;
  logic [RAW-1:0]          out_ptr_q, out_ptr_d;

  logic signed [IN_W-1:0]  w_mem_q [MN];
  logic signed [IN_W-1:0]  b_mem_q [M];
  logic signed [IN_W-1:0]  x_mem_q [N];
  logic signed [OUT_W-1:0] res_q   [M];

  logic                    w_s_fire;
  logic [PW-1:0]           w_eff_ptr;
  logic                    w_we, b_we, x_we;
  logic [WAW-1:0]          w_waddr;
  logic [RAW-1:0]          b_waddr;
  logic [CAW-1:0]          x_waddr;
  logic [RAW-1:0]          w_out_nxt;
  logic                    w_mac_valid;
  logic signed [OUT_W-1:0] w_seed;
  logic signed [OUT_W-1:0] w_mac_res;
  logic                    w_mac_vout;

  assign w_s_fire  = bus.s_valid && s_ready_q;
  // A reuse frame jumps straight to the bias section of the frame.
  assign w_eff_ptr = (in_ptr_q == '0 && bus.reuse_w && w_loaded_q) ? PW'(MN) : in_ptr_q;
  assign w_waddr   = WAW'(w_eff_ptr);
  assign b_waddr   = RAW'(w_eff_ptr - PW'(MN));
  assign x_waddr   = CAW'(w_eff_ptr - PW'(MN + M));
  assign w_out_nxt = out_ptr_q + 1'b1;
  assign w_seed    = OUT_W'(b_mem_q[iss_row_q]);

  mvm_mac #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mac (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (w_mac_valid),
    .clear_i  (iss_col_q == '0),
    .last_i   (iss_col_q == CAW'(N - 1)),
    .seed_i   (w_seed),
    .a_i      (w_mem_q[iss_idx_q]),
    .b_i      (x_mem_q[iss_col_q]),
    .result_o (w_mac_res),
    .valid_o  (w_mac_vout)
  );

  // Next-state and output decode for LOAD / CALC / OUT
  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    m_valid_d   = m_valid_q;
    data_out_d  = data_out_q;
    in_ptr_d    = in_ptr_q;
    w_loaded_d  = w_loaded_q;
    iss_idx_d   = iss_idx_q;
    iss_row_d   = iss_row_q;
    iss_col_d   = iss_col_q;
    iss_done_d  = iss_done_q;
    ret_row_d   = ret_row_q;
    out_ptr_d   = out_ptr_q;
    w_we        = 1'b0;
    b_we        = 1'b0;
    x_we        = 1'b0;
    w_mac_valid = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready_d = 1'b1;
        if (w_s_fire) begin
          in_ptr_d = w_eff_ptr + 1'b1;
          if (w_eff_ptr < PW'(MN))          w_we = 1'b1;
          else if (w_eff_ptr < PW'(MN + M)) b_we = 1'b1;
          else                              x_we = 1'b1;
          if (w_eff_ptr == PW'(MN - 1)) w_loaded_d = 1'b1;
          if (w_eff_ptr == PW'(TOTAL - 1)) begin
            state_d    = CALC;
            s_ready_d  = 1'b0;
            in_ptr_d   = '0;
            iss_idx_d  = '0;
            iss_row_d  = '0;
            iss_col_d  = '0;
            iss_done_d = 1'b0;
            ret_row_d  = '0;
          end
        end
      end
      CALC: begin
        s_ready_d = 1'b0;
        if (!iss_done_q) begin
          w_mac_valid = 1'b1;
          iss_idx_d   = iss_idx_q + 1'b1;
          if (iss_col_q == CAW'(N - 1)) begin
            iss_col_d = '0;
            if (iss_row_q == RAW'(M - 1)) iss_done_d = 1'b1;
            else                          iss_row_d  = iss_row_q + 1'b1;
          end else begin
            iss_col_d = iss_col_q + 1'b1;
          end
        end
        if (w_mac_vout) begin
          if (ret_row_q == RAW'(M - 1)) begin
            state_d   = OUT;
            out_ptr_d = '0;
            m_valid_d = 1'b0;
          end else begin
            ret_row_d = ret_row_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (!m_valid_q) begin
          m_valid_d  = 1'b1;
          data_out_d = res_q[out_ptr_q];
        end else if (bus.m_ready) begin
          if (out_ptr_q == RAW'(M - 1)) begin
            m_valid_d = 1'b0;
            state_d   = LOAD;
            s_ready_d = 1'b1;
          end else begin
            out_ptr_d  = w_out_nxt;
            data_out_d = res_q[w_out_nxt];
          end
        end
      end
      default: begin
        state_d   = LOAD;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LOAD;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      data_out_q <= '0;
      in_ptr_q   <= '0;
      w_loaded_q <= 1'b0;
      iss_idx_q  <= '0;
      iss_row_q  <= '0;
      iss_col_q  <= '0;
      iss_done_q <= 1'b0;
      ret_row_q  <= '0;
      out_ptr_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      data_out_q <= data_out_d;
      in_ptr_q   <= in_ptr_d;
      w_loaded_q <= w_loaded_d;
      iss_idx_q  <= iss_idx_d;
      iss_row_q  <= iss_row_d;
      iss_col_q  <= iss_col_d;
      iss_done_q <= iss_done_d;
      ret_row_q  <= ret_row_d;
      out_ptr_q  <= out_ptr_d;
    end
  end

  // Operand and result storage; contents are only read after being written
  always_ff @(posedge clk) begin
    if (w_we) w_mem_q[w_waddr] <= bus.data_in;
    if (b_we) b_mem_q[b_waddr] <= bus.data_in;
    if (x_we) x_mem_q[x_waddr] <= bus.data_in;
    if (w_mac_vout) res_q[ret_row_q] <= w_mac_res;
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.data_out = data_out_q;
endmodule
`default_nettype wire
